// File: rtl/uart_tx_engine_if.sv
// Write-side port bundle of the UART TX engine: byte push handshake and FIFO status.
interface uart_tx_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LVL_W      = 5
) ();
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  tx_empty;
    logic                  tx_full;
    logic [LVL_W-1:0]      tx_level;

    // Register block side: pushes bytes, observes FIFO status.
    modport master (
        output wr_data, wr_en,
        input  tx_empty, tx_full, tx_level
    );

    // Engine side: accepts bytes, reports FIFO status.
    modport slave (
        input  wr_data, wr_en,
        output tx_empty, tx_full, tx_level
    );
endinterface

// File: rtl/uart_tx_engine.sv
// Buffered UART transmitter: FIFO, runtime frame format (5-8 data bits,
// none/even/odd parity, 1/2 stop bits), CTS gating, break, overflow and
// level-threshold interrupt. Bit timing comes from an external baud tick.
module uart_tx_engine #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             uart_clk,
    input  logic             rst_n,
    input  logic             baud_tick,
    input  logic             fifo_reset,
    input  logic             cfg_tx_en,
    input  logic [1:0]       cfg_data_bits,
    input  logic             cfg_parity_en,
    input  logic             cfg_parity_odd,
    input  logic             cfg_stop2,
    input  logic             cfg_cts_en,
    input  logic             cts_n,
    input  logic             cfg_break,
    input  logic [LVL_W-1:0] cfg_thresh,
    input  logic             overflow_clr,
    uart_tx_engine_if.slave  wr_if,
    output logic             tx_serial,
    output logic             tx_active,
    output logic             tx_done,
    output logic             tx_thresh_irq,
    output logic             tx_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK
    } state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_en_prev_q, wr_en_prev_d;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [2:0]            bit_cnt_q;
    logic [2:0]            last_q;
    logic                  par_en_q, par_bit_q, stop2_q;
    logic                  serial_q, done_q;

    logic                  full, empty, push_edge, push_ok, sc, final_tick, pop;
    logic [DATA_WIDTH-1:0] head;
    logic [2:0]            load_last;
    logic                  load_par;

    // Parity over data bits 0..last only; higher bits of the byte are not sent.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                         input logic [2:0] last,
                                         input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i <= int'(last)) p = p ^ d[i];
        end
        return p;
    endfunction

    assign full       = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty      = (level_q == '0);
    assign head       = mem[rd_ptr_q];
    assign push_edge  = wr_if.wr_en & ~wr_en_prev_q;
    assign sc         = ~empty & cfg_tx_en & ~cfg_break & (~cfg_cts_en | ~cts_n);
    assign final_tick = ((state_q == STOP1) & ~stop2_q) | (state_q == STOP2);
    // A frame starts (and the head byte leaves the FIFO) from IDLE or straight
    // out of the last stop bit, so consecutive frames have no idle gap.
    assign pop        = baud_tick & sc & ((state_q == IDLE) | final_tick);
    assign push_ok    = push_edge & (~full | pop);
    assign load_last  = {1'b0, cfg_data_bits} + 3'd4;
    assign load_par   = calc_parity(head, load_last, cfg_parity_odd);

    // FIFO pointers, level, overflow flag and push-edge detector next state.
    always_comb begin
        wr_en_prev_d = wr_if.wr_en;
        overflow_d   = (overflow_q & ~overflow_clr) | (push_edge & ~push_ok);
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        if (fifo_reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop);
        end
    end

    // FIFO control registers.
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            wr_en_prev_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            wr_en_prev_q <= wr_en_prev_d;
        end
    end

    // FIFO storage; data only, no reset needed.
    always_ff @(posedge uart_clk) begin
        if (push_ok && !fifo_reset) mem[wr_ptr_q] <= wr_if.wr_data;
    end

    // Frame FSM with registered line and done pulse; advances only on baud ticks.
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            last_q    <= 3'd7;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            serial_q  <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (baud_tick) begin
                case (state_q)
                    IDLE: begin
                        if (cfg_break) begin
                            state_q  <= BREAK;
                            serial_q <= 1'b0;
                        end else if (pop) begin
                            state_q   <= START;
                            serial_q  <= 1'b0;
                            shift_q   <= head;
                            last_q    <= load_last;
                            par_en_q  <= cfg_parity_en;
                            par_bit_q <= load_par;
                            stop2_q   <= cfg_stop2;
                        end
                    end
                    START: begin
                        serial_q  <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end
                    DATA: begin
                        if (bit_cnt_q != last_q) begin
                            shift_q   <= shift_q >> 1;
                            serial_q  <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end else if (par_en_q) begin
                            serial_q <= par_bit_q;
                            state_q  <= PARITY;
                        end else begin
                            serial_q <= 1'b1;
                            state_q  <= STOP1;
                        end
                    end
                    PARITY: begin
                        serial_q <= 1'b1;
                        state_q  <= STOP1;
                    end
                    STOP1, STOP2: begin
                        if (state_q == STOP1 && stop2_q) begin
                            state_q <= STOP2;
                        end else begin
                            done_q <= 1'b1;
                            if (pop) begin
                                state_q   <= START;
                                serial_q  <= 1'b0;
                                shift_q   <= head;
                                last_q    <= load_last;
                                par_en_q  <= cfg_parity_en;
                                par_bit_q <= load_par;
                                stop2_q   <= cfg_stop2;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    BREAK: begin
                        if (!cfg_break) begin
                            serial_q <= 1'b1;
                            state_q  <= IDLE;
                        end
                    end
                    default: begin
                        serial_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_serial      = serial_q;
    assign tx_active      = (state_q != IDLE);
    assign tx_done        = done_q;
    assign tx_overflow    = overflow_q;
    assign tx_thresh_irq  = (level_q <= cfg_thresh);
    assign wr_if.tx_empty = empty;
    assign wr_if.tx_full  = full;
    assign wr_if.tx_level = level_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: random and directed frames checked against a
// frame-level bit-sequence model.
module tb_uart_tx_engine;
    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          baud_tick = 1'b0;
    logic          fifo_reset = 1'b0;
    logic          cfg_tx_en = 1'b0;
    logic [1:0]    cfg_data_bits = 2'b11;
    logic          cfg_parity_en = 1'b0;
    logic          cfg_parity_odd = 1'b0;
    logic          cfg_stop2 = 1'b0;
    logic          cfg_cts_en = 1'b0;
    logic          cts_n = 1'b0;
    logic          cfg_break = 1'b0;
    logic [LW-1:0] cfg_thresh = '0;
    logic          overflow_clr = 1'b0;
    logic          tx_serial, tx_active, tx_done, tx_thresh_irq, tx_overflow;

    int total = 0;
    int bad   = 0;

    typedef bit bitq_t[$];

    uart_tx_engine_if #(.DATA_WIDTH(DW), .LVL_W(LW)) wif ();

    uart_tx_engine #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .uart_clk      (clk),
        .rst_n         (rst_n),
        .baud_tick     (baud_tick),
        .fifo_reset    (fifo_reset),
        .cfg_tx_en     (cfg_tx_en),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity_en (cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd),
        .cfg_stop2     (cfg_stop2),
        .cfg_cts_en    (cfg_cts_en),
        .cts_n         (cts_n),
        .cfg_break     (cfg_break),
        .cfg_thresh    (cfg_thresh),
        .overflow_clr  (overflow_clr),
        .wr_if         (wif),
        .tx_serial     (tx_serial),
        .tx_active     (tx_active),
        .tx_done       (tx_done),
        .tx_thresh_irq (tx_thresh_irq),
        .tx_overflow   (tx_overflow)
    );

    always #5 clk = ~clk;

    // One-cycle baud tick every 16 clocks.
    initial begin
        forever begin
            repeat (15) @(posedge clk);
            #1 baud_tick = 1'b1;
            @(posedge clk);
            #1 baud_tick = 1'b0;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference frame: start 0, N data bits LSB first, optional parity, stop bits.
    function automatic bitq_t frame_bits(input int data, input int nbits,
                                         input bit pen, input bit podd, input bit s2);
        bitq_t q;
        int ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            bit b;
            b = bit'((data >> i) & 1);
            ones += int'(b);
            q.push_back(b);
        end
        if (pen) q.push_back(bit'(ones % 2) ^ podd);
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        return q;
    endfunction

    task automatic set_cfg(input int nbits, input bit pen, input bit podd, input bit s2);
        cfg_data_bits  = 2'(nbits - 5);
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_stop2      = s2;
    endtask

    task automatic push(input logic [DW-1:0] d);
        @(negedge clk);
        wif.wr_data = d;
        wif.wr_en   = 1'b1;
        @(negedge clk);
        wif.wr_en   = 1'b0;
    endtask

    // Returns at the negedge just after the next tick's clock edge.
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!baud_tick && n < 40);
        @(negedge clk);
    endtask

    // Waits (bounded) for a start bit, then checks each subsequent bit period
    // against exp; after the final tick expects the line idle and the given
    // number of done pulses. brk_at/chg_at assert break or scramble the config
    // after that bit index.
    task automatic check_stream(input bitq_t exp, input int frames, input int max_wait,
                                input int lvl_after_start, input int brk_at,
                                input int chg_at, input string nm);
        int w = 0;
        int dones = 0;
        do begin
            wait_tick();
            w++;
        end while (tx_serial !== 1'b0 && w < max_wait);
        total++;
        if (tx_serial !== 1'b0) begin
            bad++;
            $display("FAIL %s_start: line=%b after %0d ticks, required 0", nm, tx_serial, w);
            return;
        end
        if (lvl_after_start >= 0) begin
            total++;
            if (wif.tx_level !== LW'(lvl_after_start)) begin
                bad++;
                $display("FAIL %s_pop_level: got %0d, required %0d", nm, wif.tx_level, lvl_after_start);
            end
        end
        for (int i = 1; i <= exp.size(); i++) begin
            wait_tick();
            if (tx_done === 1'b1) dones++;
            if (i < exp.size()) begin
                total++;
                if (tx_serial !== exp[i] || tx_active !== 1'b1) begin
                    bad++;
                    $display("FAIL %s_bit%0d: line=%b active=%b, required line=%b active=1",
                             nm, i, tx_serial, tx_active, exp[i]);
                end
            end
            if (i == brk_at) cfg_break = 1'b1;
            if (i == chg_at) begin
                cfg_data_bits  = 2'($urandom_range(0, 3));
                cfg_parity_en  = 1'($urandom_range(0, 1));
                cfg_parity_odd = 1'($urandom_range(0, 1));
                cfg_stop2      = 1'($urandom_range(0, 1));
            end
        end
        total++;
        if (dones != frames || tx_serial !== 1'b1 || tx_active !== 1'b0) begin
            bad++;
            $display("FAIL %s_end: done_pulses=%0d line=%b active=%b, required %0d 1 0",
                     nm, dones, tx_serial, tx_active, frames);
        end
    endtask

    task automatic test_reset();
        total++;
        if (tx_serial !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0 ||
            wif.tx_empty !== 1'b1 || wif.tx_full !== 1'b0 || wif.tx_level !== '0 ||
            tx_thresh_irq !== 1'b1 || tx_overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: ser=%b act=%b done=%b emp=%b full=%b lvl=%0d irq=%b ovf=%b, required 1 0 0 1 0 0 1 0",
                     tx_serial, tx_active, tx_done, wif.tx_empty, wif.tx_full, wif.tx_level,
                     tx_thresh_irq, tx_overflow);
        end
    endtask

    task automatic test_8n1();
        cfg_tx_en = 1'b0;
        set_cfg(8, 0, 0, 0);
        push(8'hA5);
        total++;
        if (wif.tx_level !== LW'(1) || wif.tx_empty !== 1'b0) begin
            bad++;
            $display("FAIL push_visible: level=%0d empty=%b, required 1 0", wif.tx_level, wif.tx_empty);
        end
        cfg_tx_en = 1'b1;
        check_stream(frame_bits(8'hA5, 8, 0, 0, 0), 1, 2, 0, -1, -1, "8n1_a5");
    endtask

    task automatic test_parity_formats();
        set_cfg(7, 1, 0, 0);
        push(8'h35);
        check_stream(frame_bits(8'h35, 7, 1, 0, 0), 1, 2, -1, -1, -1, "7e1");
        set_cfg(7, 1, 1, 1);
        push(8'h35);
        check_stream(frame_bits(8'h35, 7, 1, 1, 1), 1, 2, -1, -1, -1, "7o2");
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            int nb;
            bit pen, podd, s2;
            logic [7:0] d;
            nb   = int'($urandom_range(5, 8));
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            s2   = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            set_cfg(nb, pen, podd, s2);
            push(d);
            check_stream(frame_bits(int'(d), nb, pen, podd, s2), 1, 2, -1, -1,
                         (k % 2 == 1) ? 3 : -1, $sformatf("rand%0d", k));
        end
    endtask

    task automatic test_back_to_back();
        bitq_t exp;
        cfg_tx_en = 1'b0;
        set_cfg(8, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] d;
            bitq_t f;
            d = 8'($urandom);
            push(d);
            f = frame_bits(int'(d), 8, 0, 0, 0);
            foreach (f[j]) exp.push_back(f[j]);
        end
        total++;
        if (wif.tx_level !== LW'(3)) begin
            bad++;
            $display("FAIL b2b_level: got %0d, required 3", wif.tx_level);
        end
        cfg_tx_en = 1'b1;
        check_stream(exp, 3, 2, 2, -1, -1, "b2b");
        total++;
        if (wif.tx_level !== '0 || wif.tx_empty !== 1'b1) begin
            bad++;
            $display("FAIL b2b_drained: level=%0d empty=%b, required 0 1", wif.tx_level, wif.tx_empty);
        end
    endtask

    task automatic test_overflow();
        bitq_t exp;
        cfg_tx_en  = 1'b0;
        cfg_thresh = LW'(4);
        set_cfg(8, 0, 0, 0);
        for (int k = 0; k < 17; k++) push(8'(k));
        total++;
        if (wif.tx_full !== 1'b1 || wif.tx_level !== LW'(16) || tx_overflow !== 1'b1 ||
            tx_thresh_irq !== 1'b0) begin
            bad++;
            $display("FAIL ovf_full: full=%b level=%0d ovf=%b irq=%b, required 1 16 1 0",
                     wif.tx_full, wif.tx_level, tx_overflow, tx_thresh_irq);
        end
        @(negedge clk);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        total++;
        if (tx_overflow !== 1'b0 || wif.tx_level !== LW'(16)) begin
            bad++;
            $display("FAIL ovf_clear: ovf=%b level=%0d, required 0 16", tx_overflow, wif.tx_level);
        end
        for (int k = 0; k < 16; k++) begin
            bitq_t f;
            f = frame_bits(k, 8, 0, 0, 0);
            foreach (f[j]) exp.push_back(f[j]);
        end
        cfg_tx_en = 1'b1;
        check_stream(exp, 16, 2, 15, -1, -1, "ovf_drain");
        total++;
        if (tx_thresh_irq !== 1'b1 || wif.tx_empty !== 1'b1) begin
            bad++;
            $display("FAIL ovf_irq_after: irq=%b empty=%b, required 1 1", tx_thresh_irq, wif.tx_empty);
        end
        cfg_thresh = '0;
    endtask

    task automatic test_cts();
        cfg_tx_en  = 1'b1;
        cfg_cts_en = 1'b1;
        cts_n      = 1'b1;
        set_cfg(8, 0, 0, 0);
        push(8'h3C);
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            total++;
            if (tx_serial !== 1'b1 || wif.tx_level !== LW'(1)) begin
                bad++;
                $display("FAIL cts_hold%0d: line=%b level=%0d, required 1 1", k, tx_serial, wif.tx_level);
            end
        end
        cts_n = 1'b0;
        check_stream(frame_bits(8'h3C, 8, 0, 0, 0), 1, 1, 0, -1, -1, "cts_go");
        cfg_cts_en = 1'b0;
    endtask

    task automatic test_break();
        set_cfg(8, 0, 0, 0);
        push(8'h96);
        check_stream(frame_bits(8'h96, 8, 0, 0, 0), 1, 2, -1, 3, -1, "brk_frame");
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            total++;
            if (tx_serial !== 1'b0 || tx_active !== 1'b1) begin
                bad++;
                $display("FAIL brk_hold%0d: line=%b active=%b, required 0 1", k, tx_serial, tx_active);
            end
        end
        cfg_break = 1'b0;
        wait_tick();
        total++;
        if (tx_serial !== 1'b1 || tx_active !== 1'b0) begin
            bad++;
            $display("FAIL brk_release: line=%b active=%b, required 1 0", tx_serial, tx_active);
        end
    endtask

    task automatic test_fifo_reset();
        cfg_tx_en = 1'b0;
        for (int k = 0; k < 3; k++) push(8'($urandom));
        @(negedge clk);
        fifo_reset = 1'b1;
        @(negedge clk);
        fifo_reset = 1'b0;
        total++;
        if (wif.tx_level !== '0 || wif.tx_empty !== 1'b1 || tx_overflow !== 1'b0) begin
            bad++;
            $display("FAIL fifo_reset: level=%0d empty=%b ovf=%b, required 0 1 0",
                     wif.tx_level, wif.tx_empty, tx_overflow);
        end
    endtask

    task automatic test_reset_mid();
        int w = 0;
        cfg_tx_en = 1'b0;
        set_cfg(8, 0, 0, 0);
        push(8'h00);
        push(8'h00);
        cfg_tx_en = 1'b1;
        do begin
            wait_tick();
            w++;
        end while (tx_serial !== 1'b0 && w < 3);
        wait_tick();
        wait_tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (tx_serial !== 1'b1 || wif.tx_level !== '0 || wif.tx_empty !== 1'b1 ||
            tx_active !== 1'b0 || tx_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: line=%b level=%0d empty=%b active=%b done=%b, required 1 0 1 0 0",
                     tx_serial, wif.tx_level, wif.tx_empty, tx_active, tx_done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_tick();
        total++;
        if (tx_serial !== 1'b1 || tx_active !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_after: line=%b active=%b, required 1 0", tx_serial, tx_active);
        end
    endtask

    initial begin
        wif.wr_data = '0;
        wif.wr_en   = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_8n1();
        test_parity_formats();
        test_random();
        test_back_to_back();
        test_overflow();
        test_cts();
        test_break();
        test_fifo_reset();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
